// File: rtl/tis100_axi_lite_if.sv
// tis100_axi_lite_if: AXI4-Lite bus between a tis100 initiator and the register-file slave
interface tis100_axi_lite_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master(
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave(
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/tis100_axi_lite_master.sv
// tis100_axi_lite_master: single-outstanding AXI4-Lite register read/write initiator; optional watchdog via TIMEOUT_EN
module tis100_axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [3:0]                    cmd_reg,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  tis100_axi_lite_if.master             m_axi
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;
  state_t state, state_n;
  logic awvalid, awvalid_n, wvalid, wvalid_n, bready, bready_n, arvalid, arvalid_n, rready, rready_n;
  logic rsp_valid_n, busy, expire;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr, addr_n;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata, wdata_n, rsp_data_n;
  logic [1:0] rsp_resp_n;
  assign busy = state inside {WR_AW_W, WR_B, RD_AR, RD_R};
  assign m_axi.awaddr  = addr;
  assign m_axi.araddr  = addr;
  assign m_axi.wdata   = wdata;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wstrb   = '1;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;
`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expire = busy && cnt == CW'(TIMEOUT_CYCLES - 1);
  // watchdog counts busy cycles from command accept and flags the response it forces
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
    if (M_AXI_ARESET) begin
      cnt <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : busy ? cnt + CW'(1) : cnt;
      rsp_timeout <= expire ? 1'b1 : (state == RESP && rsp_ready) ? 1'b0 : rsp_timeout;
    end
`else
  assign expire = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  // state and all registered outputs
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
    if (M_AXI_ARESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      state     <= state_n;
      cmd_ready <= state_n == IDLE;
      awvalid   <= awvalid_n;
      wvalid    <= wvalid_n;
      bready    <= bready_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_resp  <= rsp_resp_n;
    end
  // next state and next register values; the watchdog overrides everything when it fires
  always_comb begin
    state_n     = state;
    awvalid_n   = awvalid;
    wvalid_n    = wvalid;
    bready_n    = bready;
    arvalid_n   = arvalid;
    rready_n    = rready;
    addr_n      = addr;
    wdata_n     = wdata;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_resp_n  = rsp_resp;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        addr_n    = C_M_AXI_ADDR_WIDTH'({cmd_reg, 2'b00});
        wdata_n   = cmd_write ? cmd_data : wdata;
        awvalid_n = cmd_write;
        wvalid_n  = cmd_write;
        arvalid_n = !cmd_write;
        state_n   = cmd_write ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        awvalid_n = awvalid && !m_axi.awready;
        wvalid_n  = wvalid && !m_axi.wready;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = WR_B;
        end
      end
      WR_B: if (m_axi.bvalid) begin
        rsp_resp_n  = m_axi.bresp;
        rsp_data_n  = '0;
        bready_n    = 1'b0;
        rsp_valid_n = 1'b1;
        state_n     = RESP;
      end
      RD_AR: if (m_axi.arready) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_R;
      end
      RD_R: if (m_axi.rvalid) begin
        rsp_data_n  = m_axi.rdata;
        rsp_resp_n  = m_axi.rresp;
        rready_n    = 1'b0;
        rsp_valid_n = 1'b1;
        state_n     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_n = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (expire) begin
      awvalid_n   = 1'b0;
      wvalid_n    = 1'b0;
      bready_n    = 1'b0;
      arvalid_n   = 1'b0;
      rready_n    = 1'b0;
      rsp_valid_n = 1'b1;
      rsp_data_n  = '0;
      rsp_resp_n  = 2'b10;
      state_n     = RESP;
    end
  end
endmodule

// File: tb/tb_tis100_axi_lite_master.sv
// tb_tis100_axi_lite_master: scoreboard bench with a delay-configurable AXI-Lite slave model
module tb_tis100_axi_lite_master;
  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_timeout;
  logic [3:0] cmd_reg;
  logic [31:0] cmd_data, rsp_data;
  logic [1:0] rsp_resp;
  int checks = 0, fails = 0;
  int aw_dly, w_dly, b_dly, ar_dly, r_dly, b_count;
  logic ar_never;
  logic [31:0] rd_val;
  logic [1:0] rd_resp, wr_resp;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic to;} rsp_t;
  rsp_t exp_q[$];
  logic [5:0] aw_q[$], ar_q[$];
  logic [31:0] w_q[$];

  tis100_axi_lite_if bus();

  tis100_axi_lite_master #(.TIMEOUT_CYCLES(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic [1:0] r, input logic t);
    rsp_t e;
    e.data = d;
    e.resp = r;
    e.to = t;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic w, input logic [3:0] r, input logic [31:0] d);
    chk("cmd_ready_at_issue", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_reg = r;
    cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    chk("idle_wait", 32'(cmd_ready), 1);
  endtask

  // response monitor: pops the scoreboard on every consumed response
  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end

  // slave model: samples handshakes mid-cycle, updates its outputs just after each edge
  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, r_pend;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
    bus.bresp = 2'b00;
    bus.rresp = 2'b00;
    bus.rdata = '0;
    {aw_got, w_got, r_pend} = '0;
    {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
    forever begin
      @(negedge clk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs = bus.wvalid && bus.wready;
      b_hs = bus.bvalid && bus.bready;
      ar_hs = bus.arvalid && bus.arready;
      r_hs = bus.rvalid && bus.rready;
      if (aw_hs) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 32'(aw_hs), 0);
        else chk("awaddr", 32'(bus.awaddr), 32'(aw_q.pop_front()));
        chk("awprot", 32'(bus.awprot), 0);
      end
      if (w_hs) begin
        if (w_q.size() == 0) chk("w_unexpected", 32'(w_hs), 0);
        else chk("wdata", bus.wdata, w_q.pop_front());
        chk("wstrb", 32'(bus.wstrb), 'hf);
      end
      if (ar_hs) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 32'(ar_hs), 0);
        else chk("araddr", 32'(bus.araddr), 32'(ar_q.pop_front()));
        chk("arprot", 32'(bus.arprot), 0);
      end
      @(posedge clk);
      #1;
      if (rst) begin
        {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
        {aw_got, w_got, r_pend} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
      end else begin
        if (aw_hs) begin bus.awready = 1'b0; aw_got = 1'b1; aw_wait = 0; end
        else if (bus.awvalid) begin bus.awready = aw_wait >= aw_dly; aw_wait++; end
        else begin bus.awready = 1'b0; aw_wait = 0; end
        if (w_hs) begin bus.wready = 1'b0; w_got = 1'b1; w_wait = 0; end
        else if (bus.wvalid) begin bus.wready = w_wait >= w_dly; w_wait++; end
        else begin bus.wready = 1'b0; w_wait = 0; end
        if (b_hs) begin bus.bvalid = 1'b0; b_count++; end
        if (aw_got && w_got) begin
          if (b_wait >= b_dly) begin
            bus.bvalid = 1'b1;
            bus.bresp = wr_resp;
            aw_got = 1'b0;
            w_got = 1'b0;
            b_wait = 0;
          end else b_wait++;
        end
        if (ar_hs) begin bus.arready = 1'b0; r_pend = 1'b1; r_wait = 0; end
        else if (bus.arvalid && !ar_never) begin bus.arready = ar_wait >= ar_dly; ar_wait++; end
        else begin bus.arready = 1'b0; ar_wait = 0; end
        if (r_hs) bus.rvalid = 1'b0;
        if (r_pend) begin
          if (r_wait >= r_dly) begin
            bus.rvalid = 1'b1;
            bus.rdata = rd_val;
            bus.rresp = rd_resp;
            r_pend = 1'b0;
          end else r_wait++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int n, bad, b0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_reg = '0;
    cmd_data = '0;
    rsp_ready = 1'b1;
    {aw_dly, w_dly, b_dly, ar_dly, r_dly, b_count} = '0;
    ar_never = 1'b0;
    rd_val = '0;
    rd_resp = 2'b00;
    wr_resp = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_handshakes", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, rsp_timeout}), 0);
    chk("rst_regs", 32'({bus.awaddr, bus.araddr, rsp_resp}) | bus.wdata | rsp_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 1);

    // write reg 2 <- 1, zero-wait slave
    expect_rsp(32'd0, 2'b00, 1'b0);
    aw_q.push_back(6'h08);
    w_q.push_back(32'd1);
    issue(1'b1, 4'd2, 32'd1);
    @(negedge clk);
    chk("t1_aw_w_valid", 32'({bus.awvalid, bus.wvalid}), 'b11);
    chk("t1_awaddr", 32'(bus.awaddr), 'h08);
    chk("t1_wdata", bus.wdata, 1);
    chk("t1_wstrb", 32'(bus.wstrb), 'hf);
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("t1_wr_latency", n, 3);
    wait_idle();

    // write reg 4 <- 0xA5A5, WREADY two cycles ahead of AWREADY
    aw_dly = 2;
    b0 = b_count;
    expect_rsp(32'd0, 2'b00, 1'b0);
    aw_q.push_back(6'h10);
    w_q.push_back(32'h0000A5A5);
    issue(1'b1, 4'd4, 32'h0000A5A5);
    @(negedge clk);
    @(negedge clk);
    chk("t2_c2_valids", 32'({bus.awvalid, bus.wvalid}), 'b10);
    chk("t2_c2_awaddr", 32'(bus.awaddr), 'h10);
    @(negedge clk);
    chk("t2_c3_valids", 32'({bus.awvalid, bus.wvalid}), 'b10);
    chk("t2_c3_awaddr", 32'(bus.awaddr), 'h10);
    wait_idle();
    chk("t2_b_count", b_count - b0, 1);
    aw_dly = 0;

    // read reg 0, RVALID delayed 4 cycles, cmd_ready must stay low until consumed
    r_dly = 4;
    rd_val = 32'd50;
    expect_rsp(32'd50, 2'b00, 1'b0);
    ar_q.push_back(6'h00);
    issue(1'b0, 4'd0, 32'd0);
    bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (cmd_ready) bad++;
    end while (!rsp_valid && n < 50);
    chk("t3_cmd_ready_busy", bad, 0);
    chk("t3_rsp_seen", 32'(rsp_valid), 1);
    wait_idle();
    r_dly = 0;

    // read with SLVERR-style RRESP=2, response back-pressured for 5 cycles
    rsp_ready = 1'b0;
    rd_val = 32'hDEADBEEF;
    rd_resp = 2'b10;
    expect_rsp(32'hDEADBEEF, 2'b10, 1'b0);
    ar_q.push_back(6'h14);
    issue(1'b0, 4'd5, 32'd0);
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("t4_rd_latency", n, 3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'hDEADBEEF || rsp_resp !== 2'b10 || cmd_ready) bad++;
    end
    chk("t4_rsp_stable", bad, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_cmd_ready_after", 32'(cmd_ready), 1);
    chk("t4_rsp_dropped", 32'(rsp_valid), 0);
    rd_resp = 2'b00;

    // reset while waiting in WR_B abandons the write
    b_dly = 10;
    aw_q.push_back(6'h0C);
    w_q.push_back(32'd7);
    issue(1'b1, 4'd3, 32'd7);
    n = 0;
    @(negedge clk);
    while (!bus.bready && n < 20) begin @(negedge clk); n++; end
    chk("t5_in_wr_b", 32'(bus.bready), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_bready", 32'(bus.bready), 0);
    chk("t5_rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, rsp_valid, cmd_ready}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    b_dly = 0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("t5_no_rsp", bad, 0);
    wait_idle();
    rd_val = 32'h00001234;
    expect_rsp(32'h00001234, 2'b00, 1'b0);
    ar_q.push_back(6'h04);
    issue(1'b0, 4'd1, 32'd0);
    @(negedge clk);
    wait_idle();

`ifdef TIMEOUT_EN
    // slave never accepts the read address: watchdog fires after 8 cycles
    ar_never = 1'b1;
    expect_rsp(32'd0, 2'b10, 1'b1);
    issue(1'b0, 4'd6, 32'd0);
    n = 0;
    @(negedge clk);
    while (bus.arvalid && n < 50) begin n++; @(negedge clk); end
    chk("t6_arvalid_cycles", n, 8);
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    wait_idle();
    ar_never = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("addr_q_empty", 32'(aw_q.size() + w_q.size() + ar_q.size()), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
